pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage of the pipelined MIPS core. It replaces the bare PC register with four things: a configurable reset vector and exception vector, prioritised redirect selection (exception, ERET, branch, jump), a valid/ready fetch handshake toward instruction memory, and latching of redirects that arrive while a fetch request is stalled. It also detects misaligned redirect targets and vectors them to the exception handler.

## Interface
- WIDTH, 32: PC width in bits.
- RESET_VECTOR, 32'h0040_0000: PC value after reset.
- EXC_VECTOR, 32'h8000_0180: exception entry address.
- INC, 4: sequential increment.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low. Overrides every other input.
- ena  in  1  1 allows new fetch requests to issue; 0 stalls issue.
- if_ready  in  1  instruction memory accepts the current request.
- exc_req  in  1  exception redirect.
- eret_req / eret_target  in  1 / WIDTH  return from exception.
- br_taken / br_target  in  1 / WIDTH  taken branch resolved in EX.
- jmp_req / jmp_target  in  1 / WIDTH  jump.
- pc_out  out  WIDTH  registered current PC (the fetch address).
- pc_seq  out  WIDTH  pc_out + INC, combinational, modulo 2^WIDTH (used for link).
- if_valid  out  1  fetch request valid, registered.
- redirect_pending  out  1  a redirect is latched and waiting for the handshake.
- misalign  out  1  one-cycle registered pulse when a misaligned target is captured.
- bad_addr  out  WIDTH  last misaligned target, registered.

## Operation
- fire = if_valid & if_ready.
- Redirect priority: exc_req > eret_req > br_taken > jmp_req. Any of them asserted means a redirect is requested. Target T is EXC_VECTOR for exc_req, otherwise the matching *_target.
- Misalignment applies to non-exception redirects only. If T[1:0] != 0, the effective target becomes EXC_VECTOR, bad_addr <= T, and misalign pulses on the next cycle.
- Address stability: while if_valid=1 and fire=0, pc_out must not change.
- Per-cycle update, in priority order:
  - Redirect with (if_valid=0 or fire=1): pc_out <= effective T; pending cleared.
  - Redirect with if_valid=1 and fire=0: pend_target <= effective T, redirect_pending <= 1. A newer redirect overwrites the latched one, except that a latched exception target is never overwritten by ERET, branch or jump.
  - No redirect and fire=1: pc_out <= pending ? pend_target : pc_out + INC; pending cleared.
  - Otherwise: pc_out holds.
- if_valid next = ena ? 1 : (if_valid & ~fire). An asserted request is never retracted. ena=0 only blocks new requests.
- Sequential increment wraps modulo 2^WIDTH. 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset (rst_n=0, asynchronous):
  - pc_out = RESET_VECTOR
  - if_valid = 0
  - redirect_pending = 0, pend_target = 0
  - misalign = 0, bad_addr = 0
- First rising edge with rst_n=1 and ena=1: if_valid=1 with pc_out=RESET_VECTOR. The fetch at the reset vector is never skipped.
- Redirect-to-fetch latency: 1 cycle when the path is free (if_valid=0 or fire). When waiting on the handshake, the target appears on pc_out the cycle after fire.
- Redirect and fire in the same cycle: the redirect wins. The accepted request completes, and pc_out moves to T with no pc+INC fetch in between.
- Reset mid-handshake abandons the outstanding request. Memory sees if_valid drop asynchronously.
- misalign is high for exactly one cycle per captured misaligned target.

## Test plan
- Reset and stream: release rst_n with ena=1 and if_ready=1 held. Required:
  - pc_out sequence 0x00400000, 0x00400004, 0x00400008
  - if_valid=1 from the first edge
- Back-pressure: if_ready=0 for 3 cycles at pc=0x00400008. Required:
  - pc_out and if_valid stable for 3 cycles
  - after if_ready=1, next pc_out = 0x0040000C
- Stalled redirect: br_taken with br_target=0x00400100 while if_valid=1 and if_ready=0. Required:
  - redirect_pending=1
  - pc_out unchanged until fire, then 0x00400100
  - no intermediate +4 address
- Priority: exc_req, br_taken and jmp_req in the same cycle. Required:
  - pc_out = 0x80000180
  - a following jmp while pending does not overwrite a latched exception
- Misaligned target: jmp_target=0x00400102. Required:
  - pc_out = 0x80000180
  - bad_addr = 0x00400102
  - misalign high for 1 cycle
- Wrap and async reset: pc=0xFFFFFFFC with fire gives 0x00000000. Drop rst_n mid-cycle; required: immediate return to 0x00400000 and if_valid=0.

Source files
------------

// File: rtl/pc_gen.sv
//==============================================================================
// Module   : pc_gen
// Purpose  : Program-counter generator for the fetch stage. It holds the fetch
//            address and applies redirects in the order exception, ERET,
//            branch, jump. A redirect that arrives while a fetch request is
//            stalled is latched and applied once that request is accepted.
//            Misaligned non-exception targets are sent to the exception
//            vector, and the offending target is recorded.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk              in   clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   ena              in   allow a new fetch request to issue
//   if_ready         in   instruction memory accepts the current request
//   exc_req          in   exception redirect to EXC_VECTOR
//   eret_req         in   return-from-exception redirect
//   eret_target      in   ERET destination
//   br_taken         in   taken branch redirect
//   br_target        in   branch destination
//   jmp_req          in   jump redirect
//   jmp_target       in   jump destination
//   pc_out           out  registered fetch address
//   pc_seq           out  pc_out + INC (modulo 2^WIDTH), for link values
//   if_valid         out  fetch request valid
//   redirect_pending out  a redirect is latched behind a stalled request
//   misalign         out  one-cycle pulse when a misaligned target is taken
//   bad_addr         out  last misaligned target
//==============================================================================
`default_nettype none

module pc_gen #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0040_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int               INC          = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             if_ready,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] eret_target,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_req,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_seq,
  output logic             if_valid,
  output logic             redirect_pending,
  output logic             misalign,
  output logic [WIDTH-1:0] bad_addr
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  logic             fire;
  logic             redirect;
  logic [WIDTH-1:0] raw_target;
  logic             misaligned_tgt;
  logic [WIDTH-1:0] eff_target;
  logic             eff_is_exc;
  logic             keep_latched;

  // Target currently latched behind a stalled request, and whether it is
  // an exception entry (which lower-priority redirects may not displace).
  logic [WIDTH-1:0] pend_target;
  logic             pend_is_exc;

  assign fire   = if_valid & if_ready;
  assign pc_seq = pc_out + INC_W;

  always_comb begin
    redirect   = exc_req | eret_req | br_taken | jmp_req;
    raw_target = '0;
    if (exc_req)       raw_target = EXC_VECTOR;
    else if (eret_req) raw_target = eret_target;
    else if (br_taken) raw_target = br_target;
    else if (jmp_req)  raw_target = jmp_target;

    // Exception entry is never checked; every other target must be
    // word aligned or it is replaced by the exception vector.
    misaligned_tgt = redirect & ~exc_req & (raw_target[1:0] != 2'b00);
    eff_target     = misaligned_tgt ? EXC_VECTOR : raw_target;
    eff_is_exc     = exc_req | misaligned_tgt;

    keep_latched   = redirect_pending & pend_is_exc & ~eff_is_exc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out           <= RESET_VECTOR;
      if_valid         <= 1'b0;
      redirect_pending <= 1'b0;
      pend_target      <= '0;
      pend_is_exc      <= 1'b0;
      misalign         <= 1'b0;
      bad_addr         <= '0;
    end else begin
      // A request once raised stays up until accepted; ena only gates new ones.
      if_valid <= ena | (if_valid & ~fire);
      misalign <= misaligned_tgt;
      if (misaligned_tgt) begin
        bad_addr <= raw_target;
      end

      if (redirect) begin
        if (!if_valid || fire) begin
          // Path is free (or the outstanding request completes now):
          // jump straight to the target, dropping any older latched one.
          pc_out           <= eff_target;
          redirect_pending <= 1'b0;
          pend_is_exc      <= 1'b0;
        end else begin
          // Request stalled: pc_out must stay put, so park the target.
          redirect_pending <= 1'b1;
          if (!keep_latched) begin
            pend_target <= eff_target;
            pend_is_exc <= eff_is_exc;
          end
        end
      end else if (fire) begin
        pc_out           <= redirect_pending ? pend_target : pc_seq;
        redirect_pending <= 1'b0;
        pend_is_exc      <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none

module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        if_ready;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] eret_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_req;
  logic [31:0] jmp_target;
  logic [31:0] pc_out;
  logic [31:0] pc_seq;
  logic        if_valid;
  logic        redirect_pending;
  logic        misalign;
  logic [31:0] bad_addr;

  pc_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ena              (ena),
    .if_ready         (if_ready),
    .exc_req          (exc_req),
    .eret_req         (eret_req),
    .eret_target      (eret_target),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .jmp_req          (jmp_req),
    .jmp_target       (jmp_target),
    .pc_out           (pc_out),
    .pc_seq           (pc_seq),
    .if_valid         (if_valid),
    .redirect_pending (redirect_pending),
    .misalign         (misalign),
    .bad_addr         (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] exp;
  } chk_t;

  // Expected fetch addresses, in the order they must be accepted.
  logic [31:0] exp_q[$];
  // Status samples taken by the stimulus, compared by the monitor.
  chk_t        chk_q[$];
  logic        done;

  int total;
  int bad;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] g, input logic [31:0] e);
    chk_t c;
    c.name = n;
    c.got  = g;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_q.push_back(a);
  endtask

  // Stimulus: inputs change 1 time unit after each rising edge.
  initial begin
    done        = 1'b0;
    rst_n       = 1'b0;
    ena         = 1'b0;
    if_ready    = 1'b0;
    exc_req     = 1'b0;
    eret_req    = 1'b0;
    eret_target = '0;
    br_taken    = 1'b0;
    br_target   = '0;
    jmp_req     = 1'b0;
    jmp_target  = '0;
    repeat (3) step();

    chk("rst_pc",       pc_out,                 32'h0040_0000);
    chk("rst_pc_seq",   pc_seq,                 32'h0040_0004);
    chk("rst_valid",    32'(if_valid),          32'd0);
    chk("rst_pending",  32'(redirect_pending),  32'd0);
    chk("rst_misalign", 32'(misalign),          32'd0);
    chk("rst_bad_addr", bad_addr,               32'd0);

    // Reset release and sequential stream
    rst_n    = 1'b1;
    ena      = 1'b1;
    if_ready = 1'b1;
    expect_fetch(32'h0040_0000);
    expect_fetch(32'h0040_0004);
    step();
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_pc",    pc_out,        32'h0040_0000);
    step();
    chk("stream_pc1",  pc_out,        32'h0040_0004);
    step();
    chk("stream_pc2",  pc_out,        32'h0040_0008);

    // Back-pressure
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_pc_hold",    pc_out,        32'h0040_0008);
      chk("bp_valid_hold", 32'(if_valid), 32'd1);
    end
    if_ready = 1'b1;
    expect_fetch(32'h0040_0008);
    step();
    chk("bp_resume_pc", pc_out, 32'h0040_000C);

    // Branch arriving while the request is stalled
    if_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h0040_0100;
    step();
    br_taken = 1'b0;
    chk("stall_br_pending", 32'(redirect_pending), 32'd1);
    chk("stall_br_pc_hold", pc_out,                32'h0040_000C);
    step();
    chk("stall_br_pc_hold2", pc_out, 32'h0040_000C);
    if_ready = 1'b1;
    expect_fetch(32'h0040_000C);
    step();
    chk("stall_br_target",  pc_out,                32'h0040_0100);
    chk("stall_br_cleared", 32'(redirect_pending), 32'd0);

    // Priority: exception beats branch and jump, then a later jump
    // must not displace the latched exception target.
    if_ready   = 1'b0;
    exc_req    = 1'b1;
    br_taken   = 1'b1;
    br_target  = 32'h0040_0200;
    jmp_req    = 1'b1;
    jmp_target = 32'h0040_0300;
    step();
    exc_req    = 1'b0;
    br_taken   = 1'b0;
    jmp_target = 32'h0040_0400;
    chk("prio_pending", 32'(redirect_pending), 32'd1);
    step();
    jmp_req = 1'b0;
    chk("prio_pc_hold", pc_out, 32'h0040_0100);
    if_ready = 1'b1;
    expect_fetch(32'h0040_0100);
    step();
    chk("prio_exc_pc", pc_out, 32'h8000_0180);

    // Misaligned jump taken together with a fire
    jmp_req    = 1'b1;
    jmp_target = 32'h0040_0102;
    expect_fetch(32'h8000_0180);
    step();
    jmp_req = 1'b0;
    chk("mis_pc",       pc_out,        32'h8000_0180);
    chk("mis_bad_addr", bad_addr,      32'h0040_0102);
    chk("mis_pulse",    32'(misalign), 32'd1);
    expect_fetch(32'h8000_0180);
    step();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_next_pc",   pc_out,        32'h8000_0184);

    // Wrap-around of the sequential increment
    jmp_req    = 1'b1;
    jmp_target = 32'hFFFF_FFFC;
    expect_fetch(32'h8000_0184);
    step();
    jmp_req = 1'b0;
    chk("wrap_top_pc",  pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc_seq",  pc_seq, 32'h0000_0000);
    expect_fetch(32'hFFFF_FFFC);
    step();
    chk("wrap_pc",      pc_out,        32'h0000_0000);
    chk("wrap_valid",   32'(if_valid), 32'd1);

    // Asynchronous reset in the middle of a cycle
    if_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc",      pc_out,                32'h0040_0000);
    chk("async_rst_valid",   32'(if_valid),         32'd0);
    chk("async_rst_pending", 32'(redirect_pending), 32'd0);
    done = 1'b1;
  end

  // Monitor: compares queued samples and every accepted fetch at the
  // falling edge, away from the edge where the DUT updates.
  initial begin
    chk_t        c;
    logic [31:0] e;
    total = 0;
    bad   = 0;
    forever begin
      @(negedge clk);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        total++;
        if (c.got !== c.exp) begin
          bad++;
          $display("FAIL %s: got=%h expected=%h", c.name, c.got, c.exp);
        end
      end
      if (rst_n && if_valid && if_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL fetch_unexpected: got=%h expected=none", pc_out);
        end else begin
          e = exp_q.pop_front();
          if (pc_out !== e) begin
            bad++;
            $display("FAIL fetch_addr: got=%h expected=%h", pc_out, e);
          end
        end
      end
      if (done) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL fetch_missing: got=%0d outstanding expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
